demux_dsr: RTL

Deserializing demultiplexer: the inverse of the team's parametric multiplexer. It accepts a stream of `W_DW`-bit words over a valid/ready handshake and steers consecutive words into lanes 0..2**N_SEL-1 of an `in_bus_t`-shaped bus. When every lane is filled, it presents the bus on a registered valid/ready output. It is double-buffered (assembly register plus output register), so a full-rate input stream is sustained while the downstream consumer holds a word.

---
 rtl/demux_dsr.sv | 49 ++++
 1 files changed

// File: rtl/demux_dsr.sv
// demux_dsr: deserializing demultiplexer, W_DW-bit words assembled into an N_LN-lane double-buffered bus
module demux_dsr #(
  parameter int W_DW = 6,
  parameter int N_SEL = 2,
  localparam int N_LN = 2 ** N_SEL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_valid,
  input  logic [W_DW-1:0]        i_data,
  output logic                   o_ready,
  output logic [N_SEL-1:0]       o_lane,
  output logic                   o_valid,
  output logic [N_LN*W_DW-1:0]   o_bus,
  input  logic                   i_ready
);
  logic [N_LN-1:0][W_DW-1:0] asm, asm_nxt, out_reg;
  logic [N_SEL-1:0] ptr;
  logic asm_full, accept, last, out_free, load_held;
  assign o_ready = ~asm_full & ~i_clear;
  assign o_lane = ptr;
  assign o_bus = out_reg;
  assign accept = i_valid & o_ready;
  assign last = accept & (&ptr);
  assign out_free = ~o_valid | i_ready;
  assign load_held = asm_full & out_free & ~i_clear;
  // assembly register with the incoming word merged into the current lane
  always_comb begin
    asm_nxt = asm;
    asm_nxt[ptr] = i_data;
  end
  // frame state: write pointer, waiting-frame flag and output stage
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      asm <= '0;
      out_reg <= '0;
      ptr <= '0;
      asm_full <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      if (accept) asm <= asm_nxt;
      ptr <= i_clear ? '0 : ptr + N_SEL'(accept);
      asm_full <= ~i_clear & ~out_free & (asm_full | last);
      if (last & out_free) out_reg <= asm_nxt;
      else if (load_held) out_reg <= asm;
      o_valid <= (last & out_free) | load_held | (o_valid & ~i_ready);
    end
endmodule
